rv_instr_encoder: RTL and testbench

Encoder counterpart of the pipeline's main opcode decoder. Accepts symbolic instruction commands (class, registers, funct3, immediate) and assembles legal RV32I 32-bit instruction words. Streams them over a valid/ready interface into the fetch-side instruction injector used by debug and self-test.
Expands the LI pseudo-op into LUI+ADDI under a small state machine, and registers every output word.

---
 rtl/rv_instr_encoder_if.sv | 29 ++
 rtl/rv_instr_encoder.sv | 205 ++++++++++++++++++++
 tb/tb_rv_instr_encoder.sv | 352 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rv_instr_encoder_if.sv
// Command/instruction stream bundle between the symbolic command source and the encoder.
// slave = encoder side; master = command source plus instruction consumer.
interface rv_instr_encoder_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [3:0]  cmd_class;
    logic [2:0]  cmd_funct3;
    logic        cmd_f7b5;
    logic [4:0]  cmd_rd;
    logic [4:0]  cmd_rs1;
    logic [4:0]  cmd_rs2;
    logic [31:0] cmd_imm;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic        err_illegal;

    modport slave (
        input  cmd_valid, cmd_class, cmd_funct3, cmd_f7b5, cmd_rd, cmd_rs1, cmd_rs2, cmd_imm,
        input  instr_ready,
        output cmd_ready, instr_valid, instr, err_illegal
    );

    modport master (
        output cmd_valid, cmd_class, cmd_funct3, cmd_f7b5, cmd_rd, cmd_rs1, cmd_rs2, cmd_imm,
        output instr_ready,
        input  cmd_ready, instr_valid, instr, err_illegal
    );
endinterface

// File: rtl/rv_instr_encoder.sv
// Assembles RV32I words from symbolic commands and streams them out; LI expands to LUI+ADDI.
// Optional immediate range checking is enabled by defining RV_ENC_RANGE_CHECK_EN.
module rv_instr_encoder #(
    parameter logic [31:0] NOP_WORD = 32'h0000_0013,
    parameter bit          LI_OPT   = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    rv_instr_encoder_if.slave  bus
);
    localparam int unsigned XLEN = 32;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [3:0] CLS_LOAD   = 4'd0;
    localparam logic [3:0] CLS_STORE  = 4'd1;
    localparam logic [3:0] CLS_RTYPE  = 4'd2;
    localparam logic [3:0] CLS_BRANCH = 4'd3;
    localparam logic [3:0] CLS_IALU   = 4'd4;
    localparam logic [3:0] CLS_JAL    = 4'd5;
    localparam logic [3:0] CLS_JALR   = 4'd6;
    localparam logic [3:0] CLS_LUI    = 4'd7;
    localparam logic [3:0] CLS_AUIPC  = 4'd8;
    localparam logic [3:0] CLS_LI     = 4'd9;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_LI2  = 1'b1
    } state_e;

    state_e            state_q, state_d;
    logic [XLEN-1:0]   instr_q, instr_d;
    logic              valid_q, valid_d;
    logic              err_q, err_d;
    logic [4:0]        li_rd_q, li_rd_d;
    logic [11:0]       li_lo_q, li_lo_d;

    logic              cmd_ready_c;
    logic              cmd_fire_c;

    logic [XLEN-1:0]   enc_word_c;
    logic              enc_illegal_c;
    logic              enc_two_c;
    logic              imm_oor_c;
    logic [19:0]       li_up_c;
    logic [11:0]       li_lo_c;
    logic [XLEN-1:0]   acc_word_c;
    logic              acc_err_c;
    logic              acc_two_c;

    logic [XLEN-1:0]   imm;
    logic [4:0]        rd, rs1, rs2;
    logic [2:0]        f3;

    assign imm = bus.cmd_imm;
    assign rd  = bus.cmd_rd;
    assign rs1 = bus.cmd_rs1;
    assign rs2 = bus.cmd_rs2;
    assign f3  = bus.cmd_funct3;

    // Ready is forced low while reset is asserted so nothing is accepted mid-reset.
    assign cmd_ready_c = rst_n && (state_q == S_IDLE) && (!valid_q || bus.instr_ready);
    assign cmd_fire_c  = bus.cmd_valid && cmd_ready_c;

    // Combinational word assembly for the command currently on the bus.
    always_comb begin
        enc_word_c    = NOP_WORD;
        enc_illegal_c = 1'b0;
        enc_two_c     = 1'b0;
        li_up_c       = imm[31:12] + 20'(imm[11]);
        li_lo_c       = imm[11:0];
        case (bus.cmd_class)
            CLS_LOAD:   enc_word_c = {imm[11:0], rs1, f3, rd, OP_LOAD};
            CLS_STORE:  enc_word_c = {imm[11:5], rs2, rs1, f3, imm[4:0], OP_STORE};
            CLS_RTYPE:  enc_word_c = {1'b0, bus.cmd_f7b5, 5'd0, rs2, rs1, f3, rd, OP_RTYPE};
            CLS_BRANCH: enc_word_c = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], OP_BRANCH};
            CLS_IALU: begin
                if (f3 == 3'b001) begin
                    enc_word_c = {7'd0, imm[4:0], rs1, f3, rd, OP_IALU};
                end else if (f3 == 3'b101) begin
                    enc_word_c = {1'b0, bus.cmd_f7b5, 5'd0, imm[4:0], rs1, f3, rd, OP_IALU};
                end else begin
                    enc_word_c = {imm[11:0], rs1, f3, rd, OP_IALU};
                end
            end
            CLS_JAL:    enc_word_c = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OP_JAL};
            CLS_JALR:   enc_word_c = {imm[11:0], rs1, 3'b000, rd, OP_JALR};
            CLS_LUI:    enc_word_c = {imm[31:12], rd, OP_LUI};
            CLS_AUIPC:  enc_word_c = {imm[31:12], rd, OP_AUIPC};
            CLS_LI: begin
                if (LI_OPT && (li_up_c == 20'd0)) begin
                    enc_word_c = {li_lo_c, 5'd0, 3'b000, rd, OP_IALU};
                end else if (LI_OPT && (li_lo_c == 12'd0)) begin
                    enc_word_c = {li_up_c, rd, OP_LUI};
                end else begin
                    enc_word_c = {li_up_c, rd, OP_LUI};
                    enc_two_c  = 1'b1;
                end
            end
            default:    enc_illegal_c = 1'b1;
        endcase
    end

`ifdef RV_ENC_RANGE_CHECK_EN
    logic fits12_c, fits13_c, fits21_c;

    assign fits12_c = (imm == {{20{imm[11]}}, imm[11:0]});
    assign fits13_c = (imm == {{19{imm[12]}}, imm[12:0]});
    assign fits21_c = (imm == {{11{imm[20]}}, imm[20:0]});

    // Immediates that cannot be represented exactly by the target format.
    always_comb begin
        imm_oor_c = 1'b0;
        case (bus.cmd_class)
            CLS_LOAD, CLS_STORE, CLS_JALR: imm_oor_c = !fits12_c;
            CLS_IALU:                      imm_oor_c = !fits12_c;
            CLS_BRANCH:                    imm_oor_c = !fits13_c || imm[0];
            CLS_JAL:                       imm_oor_c = !fits21_c || imm[0];
            CLS_LUI, CLS_AUIPC:            imm_oor_c = (imm[11:0] != 12'd0);
            default:                       imm_oor_c = 1'b0;
        endcase
    end
`else
    assign imm_oor_c = 1'b0;
`endif

    assign acc_err_c  = enc_illegal_c || imm_oor_c;
    assign acc_word_c = acc_err_c ? NOP_WORD : enc_word_c;
    assign acc_two_c  = enc_two_c && !acc_err_c;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        if (state_q == S_IDLE) begin
            if (cmd_fire_c && acc_two_c) begin
                state_d = S_LI2;
            end
        end else begin
            if (bus.instr_ready) begin
                state_d = S_IDLE;
            end
        end
    end

    // Output/datapath next values; the LI tail is only loaded once the LUI word is taken.
    always_comb begin
        instr_d = instr_q;
        valid_d = valid_q;
        err_d   = 1'b0;
        li_rd_d = li_rd_q;
        li_lo_d = li_lo_q;
        if (state_q == S_LI2) begin
            if (bus.instr_ready) begin
                instr_d = {li_lo_q, li_rd_q, 3'b000, li_rd_q, OP_IALU};
            end
        end else if (cmd_fire_c) begin
            instr_d = acc_word_c;
            valid_d = 1'b1;
            err_d   = acc_err_c;
            li_rd_d = rd;
            li_lo_d = li_lo_c;
        end else if (bus.instr_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_q <= NOP_WORD;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            li_rd_q <= 5'd0;
            li_lo_q <= 12'd0;
        end else begin
            instr_q <= instr_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            li_rd_q <= li_rd_d;
            li_lo_q <= li_lo_d;
        end
    end

    assign bus.cmd_ready   = cmd_ready_c;
    assign bus.instr_valid = valid_q;
    assign bus.instr       = instr_q;
    assign bus.err_illegal = err_q;

endmodule

// File: tb/tb_rv_instr_encoder.sv
// Directed self-checking bench for rv_instr_encoder with hand-computed instruction words.
module tb_rv_instr_encoder;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    rv_instr_encoder_if bus ();

    rv_instr_encoder dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [3:0]  cls;
        logic [2:0]  f3;
        logic        f7;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic [31:0] exp;
    } vec_t;

    vec_t v [12];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input vec_t c);
        bus.cmd_class  = c.cls;
        bus.cmd_funct3 = c.f3;
        bus.cmd_f7b5   = c.f7;
        bus.cmd_rd     = c.rd;
        bus.cmd_rs1    = c.rs1;
        bus.cmd_rs2    = c.rs2;
        bus.cmd_imm    = c.imm;
        bus.cmd_valid  = 1'b1;
    endtask

    task automatic build_vectors();
        v[0]  = '{4'd4, 3'd0, 1'b0, 5'd5,  5'd0, 5'd0, 32'hFFFF_FFFF, 32'hFFF0_0293}; // addi x5,x0,-1
        v[1]  = '{4'd1, 3'd2, 1'b0, 5'd31, 5'd2, 5'd6, 32'h0000_0008, 32'h0061_2423}; // sw x6,8(x2), rd ignored
        v[2]  = '{4'd3, 3'd0, 1'b0, 5'd0,  5'd1, 5'd2, 32'hFFFF_FFFC, 32'hFE20_8EE3}; // beq x1,x2,-4
        v[3]  = '{4'd2, 3'd0, 1'b1, 5'd3,  5'd1, 5'd2, 32'h0000_0000, 32'h4020_81B3}; // sub x3,x1,x2
        v[4]  = '{4'd4, 3'd5, 1'b1, 5'd1,  5'd2, 5'd0, 32'h0000_0003, 32'h4031_5093}; // srai x1,x2,3
        v[5]  = '{4'd4, 3'd1, 1'b1, 5'd1,  5'd2, 5'd0, 32'h0000_0003, 32'h0031_1093}; // slli, f7b5 ignored
        v[6]  = '{4'd0, 3'd2, 1'b0, 5'd6,  5'd7, 5'd0, 32'h0000_000C, 32'h00C3_A303}; // lw x6,12(x7)
        v[7]  = '{4'd5, 3'd0, 1'b0, 5'd1,  5'd0, 5'd0, 32'h0000_0008, 32'h0080_00EF}; // jal x1,8
        v[8]  = '{4'd6, 3'd7, 1'b0, 5'd1,  5'd5, 5'd0, 32'h0000_0010, 32'h0102_80E7}; // jalr, funct3 forced 0
        v[9]  = '{4'd7, 3'd0, 1'b0, 5'd5,  5'd0, 5'd0, 32'hABCD_E000, 32'hABCD_E2B7}; // lui x5
        v[10] = '{4'd8, 3'd0, 1'b0, 5'd2,  5'd0, 5'd0, 32'h0000_1000, 32'h0000_1117}; // auipc x2
        v[11] = '{4'd5, 3'd0, 1'b0, 5'd0,  5'd0, 5'd0, 32'hFFFF_FFFC, 32'hFFDF_F06F}; // jal x0,-4
    endtask

    task automatic idle_bus();
        bus.cmd_valid   = 1'b0;
        bus.instr_ready = 1'b1;
        tick();
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.cmd_valid   = 1'b1;
        bus.cmd_class   = 4'd4;
        bus.cmd_funct3  = 3'd0;
        bus.cmd_f7b5    = 1'b0;
        bus.cmd_rd      = 5'd1;
        bus.cmd_rs1     = 5'd0;
        bus.cmd_rs2     = 5'd0;
        bus.cmd_imm     = 32'd1;
        bus.instr_ready = 1'b1;
        tick();
        tick();
        checks++;
        if (bus.instr_valid !== 1'b0) begin
            errors++; $display("FAIL reset_valid got %b want 0", bus.instr_valid);
        end
        checks++;
        if (bus.instr !== 32'h0000_0013) begin
            errors++; $display("FAIL reset_instr got %h want 00000013", bus.instr);
        end
        checks++;
        if (bus.err_illegal !== 1'b0) begin
            errors++; $display("FAIL reset_err got %b want 0", bus.err_illegal);
        end
        checks++;
        if (bus.cmd_ready !== 1'b0) begin
            errors++; $display("FAIL reset_cmd_ready got %b want 0", bus.cmd_ready);
        end
        bus.cmd_valid = 1'b0;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_encode();
        idle_bus();
        for (int i = 0; i < 12; i++) begin
            checks++;
            if (bus.cmd_ready !== 1'b1) begin
                errors++; $display("FAIL enc%0d_ready got %b want 1", i, bus.cmd_ready);
            end
            drive(v[i]);
            tick();
            bus.cmd_valid = 1'b0;
            checks++;
            if (bus.instr_valid !== 1'b1 || bus.instr !== v[i].exp || bus.err_illegal !== 1'b0) begin
                errors++;
                $display("FAIL enc%0d got v=%b w=%h e=%b want v=1 w=%h e=0",
                         i, bus.instr_valid, bus.instr, bus.err_illegal, v[i].exp);
            end
            tick();
            checks++;
            if (bus.instr_valid !== 1'b0) begin
                errors++; $display("FAIL enc%0d_drain got %b want 0", i, bus.instr_valid);
            end
        end
    endtask

    task automatic test_li();
        vec_t c;
        idle_bus();
        c = '{4'd9, 3'd0, 1'b0, 5'd10, 5'd0, 5'd0, 32'h1234_5FFF, 32'h0};
        drive(c);
        tick();
        bus.cmd_valid = 1'b0;
        checks++;
        if (bus.instr_valid !== 1'b1 || bus.instr !== 32'h1234_6537) begin
            errors++; $display("FAIL li_lui got v=%b w=%h want v=1 w=12346537", bus.instr_valid, bus.instr);
        end
        checks++;
        if (bus.cmd_ready !== 1'b0) begin
            errors++; $display("FAIL li2_cmd_ready got %b want 0", bus.cmd_ready);
        end
        tick();
        checks++;
        if (bus.instr_valid !== 1'b1 || bus.instr !== 32'hFFF5_0513) begin
            errors++; $display("FAIL li_addi got v=%b w=%h want v=1 w=fff50513", bus.instr_valid, bus.instr);
        end
        checks++;
        if (bus.cmd_ready !== 1'b1) begin
            errors++; $display("FAIL li_done_ready got %b want 1", bus.cmd_ready);
        end
        tick();
        checks++;
        if (bus.instr_valid !== 1'b0) begin
            errors++; $display("FAIL li_drain got %b want 0", bus.instr_valid);
        end

        c = '{4'd9, 3'd0, 1'b0, 5'd10, 5'd0, 5'd0, 32'h0000_07FF, 32'h0};
        drive(c);
        tick();
        bus.cmd_valid = 1'b0;
        checks++;
        if (bus.instr !== 32'h7FF0_0513 || bus.cmd_ready !== 1'b1) begin
            errors++; $display("FAIL li_small got w=%h rdy=%b want w=7ff00513 rdy=1", bus.instr, bus.cmd_ready);
        end
        tick();
        checks++;
        if (bus.instr_valid !== 1'b0) begin
            errors++; $display("FAIL li_small_single got %b want 0", bus.instr_valid);
        end

        c = '{4'd9, 3'd0, 1'b0, 5'd3, 5'd0, 5'd0, 32'h0000_5000, 32'h0};
        drive(c);
        tick();
        bus.cmd_valid = 1'b0;
        checks++;
        if (bus.instr !== 32'h0000_51B7 || bus.cmd_ready !== 1'b1) begin
            errors++; $display("FAIL li_upper got w=%h rdy=%b want w=000051b7 rdy=1", bus.instr, bus.cmd_ready);
        end
        tick();

        c = '{4'd9, 3'd0, 1'b0, 5'd4, 5'd0, 5'd0, 32'h0000_0000, 32'h0};
        drive(c);
        tick();
        bus.cmd_valid = 1'b0;
        checks++;
        if (bus.instr !== 32'h0000_0213 || bus.cmd_ready !== 1'b1) begin
            errors++; $display("FAIL li_zero got w=%h rdy=%b want w=00000213 rdy=1", bus.instr, bus.cmd_ready);
        end
        tick();
    endtask

    task automatic test_backpressure();
        vec_t c;
        idle_bus();
        bus.instr_ready = 1'b0;
        drive(v[0]);
        tick();
        drive(v[6]);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (bus.instr_valid !== 1'b1 || bus.instr !== v[0].exp || bus.cmd_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold%0d got v=%b w=%h rdy=%b want v=1 w=%h rdy=0",
                         k, bus.instr_valid, bus.instr, bus.cmd_ready, v[0].exp);
            end
            tick();
        end
        bus.instr_ready = 1'b1;
        #1;
        checks++;
        if (bus.cmd_ready !== 1'b1) begin
            errors++; $display("FAIL bp_release_ready got %b want 1", bus.cmd_ready);
        end
        tick();
        bus.cmd_valid = 1'b0;
        checks++;
        if (bus.instr_valid !== 1'b1 || bus.instr !== v[6].exp) begin
            errors++; $display("FAIL bp_next got v=%b w=%h want v=1 w=%h", bus.instr_valid, bus.instr, v[6].exp);
        end
        tick();

        // LUI half of an LI held under backpressure; source drops valid right after accept.
        bus.instr_ready = 1'b0;
        c = '{4'd9, 3'd0, 1'b0, 5'd10, 5'd0, 5'd0, 32'h1234_5FFF, 32'h0};
        drive(c);
        tick();
        bus.cmd_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (bus.instr_valid !== 1'b1 || bus.instr !== 32'h1234_6537 || bus.cmd_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_li_hold%0d got v=%b w=%h rdy=%b want v=1 w=12346537 rdy=0",
                         k, bus.instr_valid, bus.instr, bus.cmd_ready);
            end
            tick();
        end
        bus.instr_ready = 1'b1;
        tick();
        checks++;
        if (bus.instr_valid !== 1'b1 || bus.instr !== 32'hFFF5_0513) begin
            errors++; $display("FAIL bp_li_addi got v=%b w=%h want v=1 w=fff50513", bus.instr_valid, bus.instr);
        end
        tick();
        checks++;
        if (bus.instr_valid !== 1'b0) begin
            errors++; $display("FAIL bp_li_drain got %b want 0", bus.instr_valid);
        end
    endtask

    task automatic test_back_to_back();
        idle_bus();
        for (int i = 0; i < 4; i++) begin
            drive(v[i + 1]);
            tick();
            checks++;
            if (bus.instr_valid !== 1'b1 || bus.instr !== v[i + 1].exp) begin
                errors++;
                $display("FAIL b2b%0d got v=%b w=%h want v=1 w=%h", i, bus.instr_valid, bus.instr, v[i + 1].exp);
            end
        end
        bus.cmd_valid = 1'b0;
        tick();
        checks++;
        if (bus.instr_valid !== 1'b0) begin
            errors++; $display("FAIL b2b_dup got %b want 0", bus.instr_valid);
        end
    endtask

    task automatic test_illegal();
        vec_t c;
        idle_bus();
        c = '{4'hF, 3'd0, 1'b0, 5'd9, 5'd9, 5'd9, 32'h1234_5678, 32'h0};
        drive(c);
        tick();
        bus.cmd_valid = 1'b0;
        checks++;
        if (bus.instr_valid !== 1'b1 || bus.instr !== 32'h0000_0013 || bus.err_illegal !== 1'b1) begin
            errors++;
            $display("FAIL illegal_F got v=%b w=%h e=%b want v=1 w=00000013 e=1",
                     bus.instr_valid, bus.instr, bus.err_illegal);
        end
        tick();
        checks++;
        if (bus.err_illegal !== 1'b0) begin
            errors++; $display("FAIL illegal_pulse got %b want 0", bus.err_illegal);
        end
        c = '{4'hA, 3'd0, 1'b0, 5'd9, 5'd9, 5'd9, 32'h0, 32'h0};
        drive(c);
        tick();
        bus.cmd_valid = 1'b0;
        checks++;
        if (bus.instr !== 32'h0000_0013 || bus.err_illegal !== 1'b1) begin
            errors++; $display("FAIL illegal_A got w=%h e=%b want w=00000013 e=1", bus.instr, bus.err_illegal);
        end
        tick();
    endtask

    task automatic test_reset_in_li2();
        vec_t c;
        idle_bus();
        bus.instr_ready = 1'b0;
        c = '{4'd9, 3'd0, 1'b0, 5'd10, 5'd0, 5'd0, 32'h1234_5FFF, 32'h0};
        drive(c);
        tick();
        bus.cmd_valid = 1'b0;
        checks++;
        if (bus.instr !== 32'h1234_6537) begin
            errors++; $display("FAIL rst_li_lui got %h want 12346537", bus.instr);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.instr_valid !== 1'b0 || bus.instr !== 32'h0000_0013) begin
            errors++; $display("FAIL rst_li_async got v=%b w=%h want v=0 w=00000013", bus.instr_valid, bus.instr);
        end
        tick();
        rst_n = 1'b1;
        bus.instr_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if (bus.instr_valid !== 1'b0) begin
                errors++; $display("FAIL rst_li_no_addi%0d got v=%b w=%h want v=0", k, bus.instr_valid, bus.instr);
            end
        end
        drive(v[2]);
        tick();
        bus.cmd_valid = 1'b0;
        checks++;
        if (bus.instr_valid !== 1'b1 || bus.instr !== v[2].exp) begin
            errors++; $display("FAIL rst_li_after got v=%b w=%h want v=1 w=%h", bus.instr_valid, bus.instr, v[2].exp);
        end
        tick();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        build_vectors();
        test_reset();
        test_encode();
        test_li();
        test_backpressure();
        test_back_to_back();
        test_illegal();
        test_reset_in_li2();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
